// File: rtl/vec_dot_engine.sv
// Multi-cycle packed 16-bit dot-product engine: walks vectors A and B through the shared
// memory port, accumulates the signed pair products and writes the (optionally ReLU'd) sum.
module vec_dot_engine #(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              relu_en,
   input  logic [ADDR_W-1:0] a_base,
   input  logic [ADDR_W-1:0] b_base,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic [31:0]       result,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   input  logic [31:0]       mem_rdata,
   output logic              mem_we,
   output logic [31:0]       mem_wdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_A,
      S_RD_B,
      S_ACC,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   state_t              r_state;
   state_t              w_nextState;
   logic [ADDR_W-1:0]   r_aPtr;
   logic [ADDR_W-1:0]   r_bPtr;
   logic [ADDR_W-1:0]   r_dst;
   logic [LEN_W-1:0]    r_cnt;
   logic                r_reluQ;
   logic [31:0]         r_acc;
   logic [31:0]         r_aWord;
   logic [31:0]         r_result;

   logic [LEN_W-1:0]    w_cntNext;
   logic signed [15:0]  w_aLo;
   logic signed [15:0]  w_aHi;
   logic signed [15:0]  w_bLo;
   logic signed [15:0]  w_bHi;
   logic signed [31:0]  w_prodLo;
   logic signed [31:0]  w_prodHi;
   logic [31:0]         w_dot;
   logic [31:0]         w_final;

   // B data arrives on mem_rdata during ACC, so it is multiplied straight off the port.
   assign w_aLo     = r_aWord[15:0];
   assign w_aHi     = r_aWord[31:16];
   assign w_bLo     = mem_rdata[15:0];
   assign w_bHi     = mem_rdata[31:16];
   assign w_prodLo  = 32'(w_aLo) * 32'(w_bLo);
   assign w_prodHi  = 32'(w_aHi) * 32'(w_bHi);
   assign w_dot     = w_prodLo + w_prodHi;
   assign w_cntNext = r_cnt - LEN_W'(1);
   assign w_final   = (r_reluQ && r_acc[31]) ? 32'h0 : r_acc;
   assign result    = r_result;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  if (start) w_nextState = (len == '0) ? S_WRITE : S_RD_A;
         S_RD_A:  w_nextState = S_RD_B;
         S_RD_B:  w_nextState = S_ACC;
         S_ACC:   w_nextState = (w_cntNext != '0) ? S_RD_A : S_WRITE;
         S_WRITE: w_nextState = S_DONE;
         S_DONE:  w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   // Address and write data are forced to zero whenever no strobe is active.
   always_comb begin
      busy      = (r_state != S_IDLE);
      done      = 1'b0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = 32'h0;
      case (r_state)
         S_RD_A: begin
            mem_re   = 1'b1;
            mem_addr = r_aPtr;
         end
         S_RD_B: begin
            mem_re   = 1'b1;
            mem_addr = r_bPtr;
         end
         S_WRITE: begin
            mem_we    = 1'b1;
            mem_addr  = r_dst;
            mem_wdata = w_final;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_aPtr   <= '0;
         r_bPtr   <= '0;
         r_dst    <= '0;
         r_cnt    <= '0;
         r_reluQ  <= 1'b0;
         r_acc    <= 32'h0;
         r_aWord  <= 32'h0;
         r_result <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_aPtr  <= a_base & ALIGN_MASK;
                  r_bPtr  <= b_base & ALIGN_MASK;
                  r_dst   <= dst_addr & ALIGN_MASK;
                  r_cnt   <= len;
                  r_reluQ <= relu_en;
                  r_acc   <= 32'h0;
               end
            end
            S_RD_B: r_aWord <= mem_rdata;
            S_ACC: begin
               r_acc  <= r_acc + w_dot;
               r_aPtr <= r_aPtr + ADDR_W'(4);
               r_bPtr <= r_bPtr + ADDR_W'(4);
               r_cnt  <= w_cntNext;
            end
            S_WRITE: r_result <= w_final;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vec_dot_engine.sv
// Scoreboard bench for vec_dot_engine: stimulus queues expected memory events per run,
// a negedge monitor pops and compares each read, write and done pulse as it appears.
module tb_vec_dot_engine;

   localparam int ADDR_W = 32;
   localparam int LEN_W  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              relu_en;
   logic [ADDR_W-1:0] a_base;
   logic [ADDR_W-1:0] b_base;
   logic [ADDR_W-1:0] dst_addr;
   logic [LEN_W-1:0]  len;
   logic              busy;
   logic              done;
   logic [31:0]       result;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic [31:0]       mem_rdata = 32'h0;
   logic              mem_we;
   logic [31:0]       mem_wdata;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] memArr [0:63];
   int          cycleCnt  = 0;
   int          startEdge = 0;
   int          checks    = 0;
   int          errors    = 0;
   int          monRel;
   bit          monEn     = 1'b0;

   vec_dot_engine #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .relu_en   (relu_en),
      .a_base    (a_base),
      .b_base    (b_base),
      .dst_addr  (dst_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata)
   );

   always #5 clk = ~clk;

   // One-cycle read latency memory model.
   always @(posedge clk) begin
      mem_rdata <= mem_re ? memArr[mem_addr[7:2]] : 32'h0;
      cycleCnt  <= cycleCnt + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   task automatic pushExp(input int kind, input logic [31:0] addr, input logic [31:0] data, input int cyc);
      exp_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      e.cyc  = cyc;
      expQ.push_back(e);
   endtask

   // Expected events for a full run: reads of element i at cycles 3i+1 / 3i+2, write, done.
   task automatic expectRun(input logic [31:0] aB, input logic [31:0] bB, input logic [31:0] dA,
                            input int n, input logic [31:0] sum);
      for (int i = 0; i < n; i++) begin
         pushExp(0, (aB & ~32'h3) + 32'(4 * i), 32'h0, 3 * i + 1);
         pushExp(0, (bB & ~32'h3) + 32'(4 * i), 32'h0, 3 * i + 2);
      end
      pushExp(1, dA & ~32'h3, sum, 3 * n + 1);
      pushExp(2, 32'h0, sum, 3 * n + 2);
   endtask

   task automatic handleEvent(input int kind, input logic [31:0] addr, input logic [31:0] data, input int cyc);
      exp_t  e;
      string tag;
      tag = (kind == 0) ? "read" : (kind == 1) ? "write" : "done";
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL unexpected_%s actual=addr 0x%08h data 0x%08h cycle %0d required=no event",
                  tag, addr, data, cyc);
      end else begin
         e = expQ.pop_front();
         checkOutput({tag, "_kind"}, kind, e.kind);
         if (kind != 2) checkOutput({tag, "_addr"}, addr, e.addr);
         if (kind != 0) checkOutput({tag, "_data"}, data, e.data);
         checkOutput({tag, "_cycle"}, cyc, e.cyc);
      end
   endtask

   // Monitor: sampled on the falling edge, away from the DUT's active edge.
   always @(negedge clk) begin
      if (monEn) begin
         monRel = cycleCnt - startEdge + 1;
         if (mem_re || mem_we) checkOutput("strobe_exclusive", {31'b0, mem_re & mem_we}, 32'h0);
         if (mem_re) handleEvent(0, mem_addr, 32'h0, monRel);
         if (mem_we) handleEvent(1, mem_addr, mem_wdata, monRel);
         if (done)   handleEvent(2, 32'h0, result, monRel);
         if (!busy)  checkOutput("idle_quiet", {30'b0, mem_re, mem_we} | mem_addr | mem_wdata, 32'h0);
      end
   end

   // Called just after an active edge; returns one step into cycle 1 of the run.
   task automatic applyStimulus(input logic [31:0] aB, input logic [31:0] bB, input logic [31:0] dA,
                                input int n, input logic relu);
      a_base   = aB;
      b_base   = bB;
      dst_addr = dA;
      len      = LEN_W'(n);
      relu_en  = relu;
      start    = 1'b1;
      @(posedge clk);
      #1;
      startEdge = cycleCnt;
      start     = 1'b0;
      checkOutput("busy_cycle1", {31'b0, busy}, 32'h1);
   endtask

   task automatic waitDone(input string name, input int budget);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!done && k < budget);
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_timeout actual=no done after %0d cycles required=done", name, budget);
      end
      @(posedge clk);
      #1;
      checkOutput({name, "_busy_low"}, {31'b0, busy}, 32'h0);
      checkOutput({name, "_sb_drain"}, expQ.size(), 32'h0);
      expQ.delete();
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, "_busy"}, {31'b0, busy}, 32'h0);
      checkOutput({name, "_done"}, {31'b0, done}, 32'h0);
      checkOutput({name, "_result"}, result, 32'h0);
      checkOutput({name, "_mem_re"}, {31'b0, mem_re}, 32'h0);
      checkOutput({name, "_mem_we"}, {31'b0, mem_we}, 32'h0);
      checkOutput({name, "_mem_addr"}, mem_addr, 32'h0);
      checkOutput({name, "_mem_wdata"}, mem_wdata, 32'h0);
   endtask

   initial begin
      #100000;
      errors++;
      $display("[TB] FAIL watchdog actual=still running required=finished");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 64; i++) memArr[i] = 32'h0;
      memArr[32'h10 >> 2] = 32'h0002_0003;
      memArr[32'h40 >> 2] = 32'h0004_0005;
      memArr[32'h14 >> 2] = 32'h0000_FFFF;
      memArr[32'h44 >> 2] = 32'h0000_0002;
      memArr[32'h18 >> 2] = 32'h8000_8000;
      memArr[32'h1C >> 2] = 32'h8000_8000;
      memArr[32'h48 >> 2] = 32'h8000_8000;
      memArr[32'h4C >> 2] = 32'h8000_8000;
      memArr[32'h20 >> 2] = 32'h0001_0002;
      memArr[32'h24 >> 2] = 32'hFFFF_0005;
      memArr[32'h28 >> 2] = 32'h0010_0010;
      memArr[32'h50 >> 2] = 32'h0003_0004;
      memArr[32'h54 >> 2] = 32'h0007_0003;
      memArr[32'h58 >> 2] = 32'h0010_0010;

      reset    = 1'b1;
      start    = 1'b0;
      relu_en  = 1'b0;
      a_base   = '0;
      b_base   = '0;
      dst_addr = '0;
      len      = '0;
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      reset = 1'b0;
      monEn = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] len=1 basic product");
      expectRun(32'h10, 32'h40, 32'h80, 1, 32'd23);
      applyStimulus(32'h10, 32'h40, 32'h80, 1, 1'b0);
      waitDone("t1", 20);

      $display("[TB] negative sum without and with relu");
      expectRun(32'h14, 32'h44, 32'h84, 1, 32'hFFFF_FFFE);
      applyStimulus(32'h14, 32'h44, 32'h84, 1, 1'b0);
      waitDone("t2", 20);
      expectRun(32'h14, 32'h44, 32'h84, 1, 32'h0);
      applyStimulus(32'h14, 32'h44, 32'h84, 1, 1'b1);
      waitDone("t3", 20);

      $display("[TB] len=2 wraparound");
      expectRun(32'h18, 32'h48, 32'h88, 2, 32'h0);
      applyStimulus(32'h18, 32'h48, 32'h88, 2, 1'b0);
      waitDone("t4", 20);

      $display("[TB] len=0 with unaligned bases");
      expectRun(32'h13, 32'h43, 32'h8B, 0, 32'h0);
      applyStimulus(32'h13, 32'h43, 32'h8B, 0, 1'b0);
      waitDone("t5", 20);

      $display("[TB] len=3 with ignored second start");
      expectRun(32'h22, 32'h52, 32'h8C, 3, 32'd531);
      applyStimulus(32'h22, 32'h52, 32'h8C, 3, 1'b0);
      @(posedge clk);
      #1;
      a_base   = 32'h10;
      b_base   = 32'h40;
      dst_addr = 32'h90;
      len      = LEN_W'(1);
      relu_en  = 1'b1;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone("t6", 40);

      $display("[TB] reset in cycle 4 of len=3");
      pushExp(0, 32'h20, 32'h0, 1);
      pushExp(0, 32'h50, 32'h0, 2);
      pushExp(0, 32'h24, 32'h0, 4);
      applyStimulus(32'h20, 32'h50, 32'h94, 3, 1'b0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkAllZero("t7_after_reset");
      repeat (6) @(posedge clk);
      #1;
      checkOutput("t7_sb_drain", expQ.size(), 32'h0);
      expQ.delete();

      $display("[TB] fresh len=1 run after reset");
      expectRun(32'h10, 32'h40, 32'h98, 1, 32'd23);
      applyStimulus(32'h10, 32'h40, 32'h98, 1, 1'b1);
      waitDone("t8", 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
